// File: rtl/rr_grant_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter_if
// Request/grant bundle between the eight requesters and the round-robin
// arbiter.
//   en        : arbitration enable, gates new grants only
//   req       : level-sensitive request lines, one per requester
//   gnt       : one-hot grant (doubles as decoded chip-select)
//   gnt_idx   : encoded index of the current or last owner (select input)
//   gnt_valid : high while a grant is active
//   timeout   : one-cycle pulse on a forced revocation
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_grant_arbiter_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
);
    logic              en;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic              timeout;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter
// Round-robin arbiter for eight requesters sharing one downstream resource.
// A grant is held until its owner drops its request; one idle cycle always
// separates consecutive grants. Priority rotates to the requester after the
// last owner.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : rr_grant_arbiter_if.slave (en, req in; gnt, gnt_idx,
//            gnt_valid, timeout out). All outputs are registered.
//
// Build option:
//   ARB_TIMEOUT_EN : when defined, a grant held for MAX_HOLD cycles is
//                    force-revoked and timeout pulses for one cycle. When
//                    undefined, no hold counter exists and timeout is 0.
// ---------------------------------------------------------------------------

// One lane of the priority scan: requester LANE wins when it is requesting
// and no other requester sits closer to ptr in the cyclic scan order.
module rr_grant_lane #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3,
    parameter int LANE  = 0
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             win
);
    localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(LANE);

    logic [IDX_W-1:0] my_dist;
    logic [IDX_W-1:0] other_dist;
    logic             blocked;

    always_comb begin
        // Distance from ptr in scan order; modular wrap does the rotation.
        my_dist    = MY_IDX - ptr;
        other_dist = '0;
        blocked    = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            other_dist = IDX_W'(j) - ptr;
            if (j != LANE && req[j] && other_dist < my_dist)
                blocked = 1'b1;
        end
        win = req[LANE] & ~blocked;
    end
endmodule

module rr_grant_arbiter #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_grant_arbiter_if.slave  bus
);
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_grant_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q,     state_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;
    logic [N_REQ-1:0] gnt_q,       gnt_d;
    logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q,   timeout_d;

`ifdef ARB_TIMEOUT_EN
    // Counts completed GRANT cycles; revocation fires on the edge that would
    // end the MAX_HOLD-th cycle of ownership.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
`endif

    // ------------------------------------------------------------------
    // Winner selection: one scan lane per requester, then encode.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] win;
    logic [IDX_W-1:0] win_idx;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        rr_grant_lane #(
            .N_REQ (N_REQ),
            .IDX_W (IDX_W),
            .LANE  (i)
        ) u_lane (
            .req (bus.req),
            .ptr (ptr_q),
            .win (win[i])
        );
    end

    // win is one-hot or zero, so OR-ing indices gives the encoding.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i])
                win_idx = win_idx | IDX_W'(i);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    state_d     = GRANT;
                    gnt_d       = win;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d      = '0;
`endif
                end
            end

            GRANT: begin
                // Release has priority over timeout on the same edge.
                if (!bus.req[gnt_idx_q]) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 1'b1;
                    timeout_d   = 1'b1;
                end
                else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_q <= '0;
        else
            hold_q <= hold_d;
    end
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    // Never set without the timeout feature; kept so both builds share
    // the same register set.
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_arbiter
// Directed bench for rr_grant_arbiter: reset values, single request,
// round-robin order with wrap, enable gating, hold/timeout behaviour and
// asynchronous reset during a grant. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_rr_grant_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rr_grant_arbiter_if bus ();

    rr_grant_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        bus.en  = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b1;
        bus.req = '0;

        // ---- reset values ----
        tick();
        tick();
        chk("rst_gnt",     32'(bus.gnt),       32'h00);
        chk("rst_idx",     32'(bus.gnt_idx),   32'd0);
        chk("rst_valid",   32'(bus.gnt_valid), 32'd0);
        chk("rst_timeout", 32'(bus.timeout),   32'd0);
        rst_n = 1'b1;

        // ---- single request ----
        bus.req = 8'h04;
        tick();
        chk("single_gnt",   32'(bus.gnt),       32'h04);
        chk("single_idx",   32'(bus.gnt_idx),   32'd2);
        chk("single_valid", 32'(bus.gnt_valid), 32'd1);
        bus.req = 8'h00;
        tick();
        chk("single_rel_gnt",   32'(bus.gnt),       32'h00);
        chk("single_rel_valid", 32'(bus.gnt_valid), 32'd0);
        chk("single_rel_idx",   32'(bus.gnt_idx),   32'd2);
        // ptr is now 3: requester 3 outranks requester 0.
        bus.req = 8'h09;
        tick();
        chk("ptr3_gnt", 32'(bus.gnt), 32'h08);
        bus.req = 8'h00;
        tick();

        // ---- round-robin order 0..7,0 with req=FF ----
        do_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'(1) << (k % 8));
            chk($sformatf("rr_idx%0d", k), 32'(bus.gnt_idx), 32'(k % 8));
            bus.req[k % 8] = 1'b0;
            tick();
            chk($sformatf("rr_gap%0d", k), 32'(bus.gnt), 32'h00);
            bus.req[k % 8] = 1'b1;
        end

        // ---- wrap-around: ptr=7 with req=81 ----
        do_reset();
        bus.req = 8'h40;
        tick();
        chk("wrap_pre", 32'(bus.gnt), 32'h40);
        bus.req = 8'h00;
        tick();
        bus.req = 8'h81;
        tick();
        chk("wrap_gnt7", 32'(bus.gnt), 32'h80);
        bus.req = 8'h01;
        tick();
        chk("wrap_rel", 32'(bus.gnt), 32'h00);
        tick();
        chk("wrap_gnt0", 32'(bus.gnt), 32'h01);
        bus.req = 8'h00;
        tick();

        // ---- enable gating ----
        bus.en  = 1'b0;
        bus.req = 8'h10;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("en_off%0d", i), 32'(bus.gnt), 32'h00);
        end
        bus.en = 1'b1;
        tick();
        chk("en_on_gnt", 32'(bus.gnt), 32'h10);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("en_hold%0d", i), 32'(bus.gnt), 32'h10);
        end
        bus.req = 8'h00;
        tick();
        chk("en_rel", 32'(bus.gnt), 32'h00);
        bus.en = 1'b1;

        // ---- hold / timeout (ptr=5) ----
        bus.req = 8'h21;
        tick();
        chk("to_gnt_first", 32'(bus.gnt), 32'h20);
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("to_hold%0d", i), 32'(bus.gnt), 32'h20);
            chk($sformatf("to_nopulse%0d", i), 32'(bus.timeout), 32'd0);
        end
        tick();
        chk("to_revoke_gnt",   32'(bus.gnt),       32'h00);
        chk("to_revoke_valid", 32'(bus.gnt_valid), 32'd0);
        chk("to_pulse",        32'(bus.timeout),   32'd1);
        chk("to_idx",          32'(bus.gnt_idx),   32'd5);
        tick();
        chk("to_next_gnt",  32'(bus.gnt),     32'h01);
        chk("to_pulse_end", 32'(bus.timeout), 32'd0);
        bus.req = 8'h00;
        tick();
`else
        for (int i = 1; i < 20; i++) begin
            tick();
            chk($sformatf("hold%0d", i), 32'(bus.gnt), 32'h20);
            chk($sformatf("no_to%0d", i), 32'(bus.timeout), 32'd0);
        end
        bus.req = 8'h00;
        tick();
        chk("hold_rel", 32'(bus.gnt), 32'h00);
`endif

        // ---- asynchronous reset mid-grant ----
        bus.req = 8'h08;
        tick();
        chk("mid_gnt", 32'(bus.gnt), 32'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",   32'(bus.gnt),       32'h00);
        chk("mid_rst_valid", 32'(bus.gnt_valid), 32'd0);
        chk("mid_rst_idx",   32'(bus.gnt_idx),   32'd0);
        tick();
        rst_n   = 1'b1;
        bus.req = 8'hFF;
        tick();
        chk("post_rst_gnt", 32'(bus.gnt), 32'h01);
        chk("post_rst_idx", 32'(bus.gnt_idx), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that shares one downstream resource among eight requesters and drives a one-hot, decoder-style grant vector plus its encoded index. It sits in front of the 3-to-8 select path: the registered grant index feeds the select input, and the grant vector doubles as the decoded chip-select. Grants are held until the owner releases its request. With the optional timeout compiled in, a grant is also revoked after a bounded number of cycles.

## Interface
- N_REQ, 8, number of requesters; fixed at 8 for this revision.
- IDX_W, 3, width of the grant index; equals log2(N_REQ).
- MAX_HOLD, 16, maximum cycles a grant may be held when ARB_TIMEOUT_EN is defined; legal range 2..255.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; gates new grants only.
- req  input  8  request lines, level-sensitive, one per requester.
- gnt  output  8  one-hot grant; all zero when no grant.
- gnt_idx  output  3  binary index of the current or last owner.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is force-revoked.

## Operation
- State machine has two states.
  - IDLE: no grant active.
  - GRANT: exactly one gnt bit high.
- Round-robin pointer `ptr` (3 bits) marks the highest-priority requester.
- IDLE → GRANT when en=1 and |req=1.
  - Winner is the first set req bit scanning ptr, ptr+1, … mod 8.
  - Registered at the same edge: gnt_idx=winner, gnt=1<<winner, gnt_valid=1.
- GRANT → IDLE when req[gnt_idx] is sampled low.
  - At that edge: gnt=0, gnt_valid=0, ptr=gnt_idx+1 mod 8 (7 wraps to 0).
  - gnt_idx keeps the last owner.
- In GRANT, other req bits are ignored. en=0 does not revoke an active grant.
- In IDLE with en=0, no grant is issued and ptr is unchanged.
- Exactly one idle cycle separates consecutive grants; there are no back-to-back grants.
- Requests that appear and vanish entirely while a grant is active are not remembered.
- Invariant: gnt is always zero or one-hot, and gnt==(gnt_valid ? 1<<gnt_idx : 0).

## Timing
- Reset values, applied asynchronously on rst_n low:
  - state=IDLE, ptr=0.
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Hold counter = 0.
- Reset mid-grant clears gnt and gnt_valid immediately, without waiting for clk.
- Operation resumes at the first clk edge after rst_n rises.
- Grant latency: req sampled high in IDLE at edge k → gnt visible after edge k (one cycle, registered).
- Release latency: req[owner] sampled low at edge k → gnt=0 after edge k. The next grant can appear after edge k+1.
- All outputs are registered; there are no combinational paths from req or en to outputs.
- Timeout (ARB_TIMEOUT_EN only):
  - The hold counter clears on entry to GRANT and increments each GRANT cycle.
  - On the edge where the grant has been active for MAX_HOLD cycles: gnt=0, state=IDLE, ptr=gnt_idx+1, timeout=1 for one cycle.
  - If release and timeout occur on the same edge, release wins and timeout stays 0.

## Configuration
- ARB_TIMEOUT_EN defined:
  - Hold counter (8 bits) and forced revocation are built as described in Timing.
  - timeout pulses on each forced revocation.
- ARB_TIMEOUT_EN undefined:
  - No counter is built; grants are held indefinitely until released.
  - timeout is tied to 0. MAX_HOLD is unused.

## Test plan
- Single request:
  - req=8'h04 from IDLE → after one edge gnt=8'h04, gnt_idx=2, gnt_valid=1.
  - Drop req → gnt=0 next edge, ptr=3.
- Round-robin ordering:
  - req=8'hFF held, each owner drops and re-raises its req after its grant.
  - From reset, grant order is 0,1,2,…,7,0, each grant separated by one idle cycle.
- Wrap-around:
  - ptr=7 with req=8'h81 → gnt=8'h80.
  - After release → gnt=8'h01.
- Enable gating:
  - en=0, req=8'h10 → gnt stays 0 for 10 cycles.
  - Raise en → gnt=8'h10 after one edge.
  - Lowering en during the grant does not revoke it.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16):
  - req[5] held high → gnt=8'h20 for exactly 16 cycles, then gnt=0 and a timeout pulse of one cycle.
  - With req=8'h21 held, the next grant is 8'h01.
- Reset mid-grant:
  - During gnt=8'h08, drive rst_n low between edges → gnt=0 and gnt_valid=0 immediately, ptr=0.
  - After release of reset, req=8'hFF → gnt=8'h01.
